// File: rtl/shift_sequencer.sv
// Round-robin front end that time-shares one registered 8-bit barrel shifter (1..4 places per pass)
// among NREQ requesters, splitting 5..7-place shifts into two passes.
module shift_sequencer #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [8*NREQ-1:0]   req_data,
    input  logic [3*NREQ-1:0]   req_op,
    input  logic [3*NREQ-1:0]   req_amt,
    output logic [7:0]          sh_a,
    output logic [4:0]          sh_sel,
    input  logic [7:0]          sh_q,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [7:0]          rsp_data,
    output logic [IDW-1:0]      rsp_id,
    output logic                rsp_err,
    output logic                busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]     state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [7:0]     work, work_n;
    logic [2:0]     op_q, op_n;
    logic [2:0]     rem, rem_n;
    logic [IDW-1:0] id_q, id_n;
    logic           err_q, err_n;
    logic [7:0]     sh_a_n;
    logic [4:0]     sh_sel_n;

    logic [7:0]     data_arr [NREQ];
    logic [2:0]     op_arr   [NREQ];
    logic [2:0]     amt_arr  [NREQ];
    logic           gnt_vld;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] cand;
    logic [2:0]     rem_left;

    // Places handled by one pass: at most 4
    function automatic logic [2:0] step_f(input logic [2:0] r);
        return (r > 3'd4) ? 3'd4 : r;
    endfunction

    function automatic logic [4:0] sel_f(input logic [2:0] op, input logic [2:0] r);
        logic [2:0] places_m1;
        places_m1 = step_f(r) - 3'd1;
        return {op[2], op[1:0], places_m1[1:0]};
    endfunction

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[8*i +: 8];
        assign op_arr[i]   = req_op[3*i +: 3];
        assign amt_arr[i]  = req_amt[3*i +: 3];
    end

    // First valid requester at or after the round-robin pointer
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr) + k) % NREQ);
            if (!gnt_vld && req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt     = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_vld) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign rem_left = rem - step_f(rem);

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        work_n   = work;
        op_n     = op_q;
        rem_n    = rem;
        id_n     = id_q;
        err_n    = err_q;
        sh_a_n   = sh_a;
        sh_sel_n = sh_sel;
        case (state)
            IDLE: begin
                if (gnt_vld) begin
                    id_n   = gnt;
                    ptr_n  = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
                    op_n   = op_arr[gnt];
                    work_n = data_arr[gnt];
                    rem_n  = amt_arr[gnt];
                    err_n  = (op_arr[gnt][2:1] == 2'b11);
                    if (err_n || amt_arr[gnt] == 3'd0) begin
                        state_n = DONE;
                    end else begin
                        state_n  = ISSUE;
                        sh_a_n   = data_arr[gnt];
                        sh_sel_n = sel_f(op_arr[gnt], amt_arr[gnt]);
                    end
                end
            end
            ISSUE: state_n = WAIT;
            WAIT: begin
                work_n = sh_q;
                rem_n  = rem_left;
                if (rem_left != 3'd0) begin
                    state_n  = ISSUE;
                    sh_a_n   = sh_q;
                    sh_sel_n = sel_f(op_q, rem_left);
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            work   <= '0;
            op_q   <= '0;
            rem    <= '0;
            id_q   <= '0;
            err_q  <= 1'b0;
            sh_a   <= '0;
            sh_sel <= '0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            work   <= work_n;
            op_q   <= op_n;
            rem    <= rem_n;
            id_q   <= id_n;
            err_q  <= err_n;
            sh_a   <= sh_a_n;
            sh_sel <= sh_sel_n;
        end
    end

    assign rsp_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign rsp_data  = work;
    assign rsp_id    = id_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural shifter model plus a total-amount reference for results,
// latency and round-robin grant order.
module tb_shift_sequencer;

    localparam int unsigned NREQ = 2;
    localparam int unsigned IDW  = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [15:0] req_data = '0;
    logic [5:0]  req_op = '0;
    logic [5:0]  req_amt = '0;
    logic [7:0]  sh_a;
    logic [4:0]  sh_sel;
    logic [7:0]  sh_q = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [7:0]  rsp_data;
    logic [0:0]  rsp_id;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;

    shift_sequencer #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_op(req_op), .req_amt(req_amt),
        .sh_a(sh_a), .sh_sel(sh_sel), .sh_q(sh_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Whole-operation result by total amount
    function automatic logic [7:0] ref_result(input logic [7:0] d, input logic [2:0] op, input int amt);
        logic [15:0] dd;
        logic signed [7:0] s;
        dd = {d, d};
        s  = d;
        if (amt == 0 || op[2:1] == 2'b11) return d;
        case (op)
            3'b000, 3'b100: return 8'(d << amt);
            3'b001:         return d >> amt;
            3'b010:         begin dd = dd << amt; return dd[15:8]; end
            3'b011:         begin dd = dd >> amt; return dd[7:0]; end
            default:        return 8'(s >>> amt);
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input int amt);
        if (amt == 0 || op[2:1] == 2'b11) return 1;
        return (amt > 4) ? 5 : 3;
    endfunction

    function automatic logic [4:0] ref_sel(input logic [2:0] op, input int amt);
        int st;
        st = (amt > 4) ? 4 : amt;
        return {op[2], op[1:0], 2'(st - 1)};
    endfunction

    // External shifter: one registered pass of 1..4 places
    always @(posedge clk) sh_q <= ref_result(sh_a, {sh_sel[4], sh_sel[3:2]}, int'(sh_sel[1:0]) + 1);

    task automatic run_op(input int i, input logic [7:0] d, input logic [2:0] op, input logic [2:0] amt,
                          output bit granted, output int lat, output logic [7:0] data,
                          output logic [0:0] id, output logic err,
                          output logic [4:0] sel0, output logic [4:0] sel1, output logic [4:0] sel2);
        int n;
        granted = 1'b0; lat = 0; data = '0; id = '0; err = 1'b0; sel1 = '0; sel2 = '0;
        @(negedge clk);
        sel0 = sh_sel;
        req_data[8*i +: 8] = d;
        req_op[3*i +: 3]   = op;
        req_amt[3*i +: 3]  = amt;
        req_valid[i]       = 1'b1;
        #1;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 20) begin
            @(negedge clk); #1; n++;
        end
        if (req_ready[i] !== 1'b1) begin
            req_valid[i] = 1'b0;
            return;
        end
        granted = 1'b1;
        model_ptr = (i + 1) % 2;
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) sel1 = sh_sel;
            if (lat == 3) sel2 = sh_sel;
            if (rsp_valid === 1'b1) break;
        end
        data = rsp_data; id = rsp_id; err = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
        checks++; if (rsp_data !== 8'h00 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp_data_id got=%h/%b exp=00/0", rsp_data, rsp_id); end
        checks++; if (sh_a !== 8'h00 || sh_sel !== 5'b00000) begin errors++; $display("FAIL reset_shifter_if got=%h/%b exp=00/00000", sh_a, sh_sel); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_directed();
        bit g; int lat; logic [7:0] d; logic [0:0] id; logic e; logic [4:0] s0, s1, s2;
        run_op(0, 8'h81, 3'b000, 3'd1, g, lat, d, id, e, s0, s1, s2);
        checks++; if (!g || lat != 3) begin errors++; $display("FAIL lsl_latency got=%0d exp=3 granted=%0d", lat, g); end
        checks++; if (s1 !== 5'b00000) begin errors++; $display("FAIL lsl_sel got=%b exp=00000", s1); end
        checks++; if (d !== 8'h02 || id !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL lsl_rsp got=%h/%b/%b exp=02/0/0", d, id, e); end

        run_op(1, 8'h90, 3'b101, 3'd6, g, lat, d, id, e, s0, s1, s2);
        checks++; if (!g || lat != 5) begin errors++; $display("FAIL asr6_latency got=%0d exp=5 granted=%0d", lat, g); end
        checks++; if (s1 !== 5'b10111 || s2 !== 5'b10101) begin errors++; $display("FAIL asr6_sel got=%b,%b exp=10111,10101", s1, s2); end
        checks++; if (d !== 8'hFE || id !== 1'b1 || e !== 1'b0) begin errors++; $display("FAIL asr6_rsp got=%h/%b/%b exp=fe/1/0", d, id, e); end

        run_op(0, 8'hA5, 3'b011, 3'd7, g, lat, d, id, e, s0, s1, s2);
        checks++; if (!g || lat != 5) begin errors++; $display("FAIL ror7_latency got=%0d exp=5", lat); end
        checks++; if (s1 !== 5'b01111 || s2 !== 5'b01110) begin errors++; $display("FAIL ror7_sel got=%b,%b exp=01111,01110", s1, s2); end
        checks++; if (d !== 8'h4B) begin errors++; $display("FAIL ror7_data got=%h exp=4b", d); end

        run_op(1, 8'h3C, 3'b110, 3'd3, g, lat, d, id, e, s0, s1, s2);
        checks++; if (!g || lat != 1) begin errors++; $display("FAIL illegal_latency got=%0d exp=1", lat); end
        checks++; if (e !== 1'b1 || d !== 8'h3C || id !== 1'b1) begin errors++; $display("FAIL illegal_rsp got=%b/%h/%b exp=1/3c/1", e, d, id); end
        checks++; if (s1 !== s0) begin errors++; $display("FAIL illegal_no_issue got=%b exp=%b", s1, s0); end
    endtask

    task automatic test_random();
        bit g; int lat; logic [7:0] d; logic [0:0] id; logic e; logic [4:0] s0, s1, s2;
        int i; logic [7:0] data; logic [2:0] op, amt; bit legal;
        for (int t = 0; t < 40; t++) begin
            i    = $urandom_range(0, 1);
            data = 8'($urandom);
            op   = 3'($urandom_range(0, 7));
            amt  = 3'($urandom_range(0, 7));
            legal = (op[2:1] != 2'b11);
            run_op(i, data, op, amt, g, lat, d, id, e, s0, s1, s2);
            checks++; if (!g || lat != ref_lat(op, int'(amt))) begin errors++; $display("FAIL rand_latency op=%b amt=%0d got=%0d exp=%0d", op, amt, lat, ref_lat(op, int'(amt))); end
            checks++; if (d !== ref_result(data, op, int'(amt))) begin errors++; $display("FAIL rand_data d=%h op=%b amt=%0d got=%h exp=%h", data, op, amt, d, ref_result(data, op, int'(amt))); end
            checks++; if (id !== 1'(i) || e !== !legal) begin errors++; $display("FAIL rand_id_err got=%b/%b exp=%0d/%0d", id, e, i, !legal); end
            if (legal && amt != 3'd0) begin
                checks++; if (s1 !== ref_sel(op, int'(amt))) begin errors++; $display("FAIL rand_sel1 got=%b exp=%b", s1, ref_sel(op, int'(amt))); end
                if (amt > 3'd4) begin
                    checks++; if (s2 !== ref_sel(op, int'(amt) - 4)) begin errors++; $display("FAIL rand_sel2 got=%b exp=%b", s2, ref_sel(op, int'(amt) - 4)); end
                end
            end else begin
                checks++; if (s1 !== s0) begin errors++; $display("FAIL rand_no_issue got=%b exp=%b", s1, s0); end
            end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle_after got=%b exp=0", busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pd [2]; logic [2:0] po [2]; logic [2:0] pa [2];
        bit pend; int cnt; int plat; logic [7:0] pexp; int pid; int grants; int g; bit newpay;
        logic [1:0] exp_ready; logic exp_rv;
        pend = 1'b0; cnt = 0; plat = 0; pexp = '0; pid = 0; grants = 0; g = 0;
        for (int j = 0; j < 2; j++) begin
            pd[j] = 8'($urandom); po[j] = 3'($urandom_range(0, 5)); pa[j] = 3'($urandom_range(0, 7));
            req_data[8*j +: 8] = pd[j]; req_op[3*j +: 3] = po[j]; req_amt[3*j +: 3] = pa[j];
        end
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk); #1;
            newpay = 1'b0;
            if (pend) cnt++;
            exp_rv = pend && (cnt == plat);
            exp_ready = pend ? 2'b00 : 2'(2'b01 << model_ptr);
            checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL b2b_rsp_valid cyc=%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", c, req_ready, exp_ready); end
            if (pend && cnt == plat) begin
                checks++; if (rsp_data !== pexp || rsp_id !== 1'(pid)) begin errors++; $display("FAIL b2b_rsp got=%h/%b exp=%h/%0d", rsp_data, rsp_id, pexp, pid); end
                pend = 1'b0;
            end else if (!pend && req_ready === exp_ready) begin
                g = model_ptr;
                pend = 1'b1; cnt = 0;
                plat = ref_lat(po[g], int'(pa[g]));
                pexp = ref_result(pd[g], po[g], int'(pa[g]));
                pid = g;
                model_ptr = 1 - g;
                grants++;
                newpay = 1'b1;
            end
            @(posedge clk); #1;
            if (newpay) begin
                pd[g] = 8'($urandom); po[g] = 3'($urandom_range(0, 5)); pa[g] = 3'($urandom_range(0, 7));
                req_data[8*g +: 8] = pd[g]; req_op[3*g +: 3] = po[g]; req_amt[3*g +: 3] = pa[g];
            end
        end
        req_valid = 2'b00;
        if (pend) begin
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (rsp_valid === 1'b1) break;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        checks++; if (grants < 12) begin errors++; $display("FAIL b2b_grant_count got=%0d exp>=12", grants); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain_busy got=%b exp=0", busy); end
    endtask

    task automatic test_stall();
        int n;
        @(negedge clk);
        req_data[7:0] = 8'hF0; req_op[2:0] = 3'b001; req_amt[2:0] = 3'd2;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL stall_grant0 got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        model_ptr = 1;
        req_data[15:8] = 8'h55; req_op[5:3] = 3'b000; req_amt[5:3] = 3'd0;
        req_valid = 2'b10;
        n = 0;
        while (n < 20) begin
            @(negedge clk); n++;
            if (rsp_valid === 1'b1) break;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL stall_latency got=%0d exp=3", n); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h3C || rsp_id !== 1'b0 || rsp_err !== 1'b0 || req_ready !== 2'b00) begin
                errors++; $display("FAIL stall_hold cyc=%0d got=%b/%h/%b/%b/%b exp=1/3c/0/0/00", k, rsp_valid, rsp_data, rsp_id, rsp_err, req_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 2'b10 || busy !== 1'b0) begin errors++; $display("FAIL stall_next_grant got=%b/%b exp=10/0", req_ready, busy); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        model_ptr = 0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h55 || rsp_id !== 1'b1) begin errors++; $display("FAIL stall_second_rsp got=%b/%h/%b exp=1/55/1", rsp_valid, rsp_data, rsp_id); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_data[7:0] = 8'($urandom); req_op[2:0] = 3'b010; req_amt[2:0] = 3'd3;
        req_valid = 2'b01;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_grant got=%b exp=01", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        model_ptr = 1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_in_wait got=%b/%b exp=1/0", busy, rsp_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        model_ptr = 0;
        checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || sh_sel !== 5'b00000 || sh_a !== 8'h00) begin errors++; $display("FAIL rstmid_state got=%b/%b/%b/%h exp=0/0/00000/00", busy, rsp_valid, sh_sel, sh_a); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp cyc=%0d got=%b exp=0", k, rsp_valid); end
        end
        req_amt = '0;
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_ptr got=%b exp=01", req_ready); end
        req_valid = 2'b00;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
